// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants and types for the processor control unit
//
// Purpose: opcode constants, FSM state encoding and datapath widths shared by
//          the control unit and anything that decodes its instruction word.
// Ports:   none (package).
package proc_pkg;

    localparam int DATA_W = 4;
    localparam int IW     = 6;

    // Instruction word layout: {op[1:0], X[1:0], Y[1:0]}
    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_T1   = 2'b01,
        S_T2   = 2'b10,
        S_T3   = 2'b11
    } state_t;

endpackage

// File: rtl/dec2to4.sv
// rtl/dec2to4.sv - 2-bit index to 4-bit one-hot decoder
//
// Purpose: turns a register index into a one-hot register select.
// Ports:   sel    - 2-bit register index
//          onehot - 4-bit one-hot select, bit sel set
module dec2to4 (
    input  logic [1:0] sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot      = 4'b0000;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/proc_control_unit.sv
// rtl/proc_control_unit.sv - instruction sequencing FSM for the 4-bit datapath
//
// Purpose: latches an instruction on Run (in IDLE) and steps a Moore FSM that
//          drives register-file, accumulator and bus-source controls.
// Ports:   Clock  - system clock, rising edge
//          Reset  - asynchronous active-high reset to IDLE, IR cleared
//          Run    - start request, sampled only in IDLE
//          Instr  - instruction word {op, X, Y}, captured on accepted Run
//          Rin    - one-hot register load enables R0..R3
//          Rout   - one-hot register bus-drive enables R0..R3
//          Ain    - A register load enable
//          Gin    - G register load enable
//          Gout   - drive G onto the bus
//          Extern - drive external data onto the bus
//          AddSub - adder mode, 0 = add, 1 = subtract
//          Done   - one-cycle pulse in the final cycle of an instruction
//          Busy   - high in every state other than IDLE
module proc_control_unit #(
    parameter int NREG = 4,
    parameter int IW   = 6
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Run,
    input  logic [IW-1:0]   Instr,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            Extern,
    output logic            AddSub,
    output logic            Done,
    output logic            Busy
);

    import proc_pkg::state_t;
    import proc_pkg::S_IDLE;
    import proc_pkg::S_T1;
    import proc_pkg::S_T2;
    import proc_pkg::S_T3;
    import proc_pkg::OP_MV;
    import proc_pkg::OP_MVI;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ir;

    logic [1:0]      op;
    logic [1:0]      rx;
    logic [1:0]      ry;
    logic [NREG-1:0] x_hot;
    logic [NREG-1:0] y_hot;

    assign op = ir[5:4];
    assign rx = ir[3:2];
    assign ry = ir[1:0];

    dec2to4 u_dec_x (
        .sel    (rx),
        .onehot (x_hot)
    );

    dec2to4 u_dec_y (
        .sel    (ry),
        .onehot (y_hot)
    );

    // State and IR share one register block so reset clears both together.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && Run) begin
                ir <= Instr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (Run) state_nxt = S_T1;
            // op[1] set means add/sub, which need the two extra steps
            S_T1:   state_nxt = op[1] ? S_T2 : S_IDLE;
            S_T2:   state_nxt = S_T3;
            S_T3:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore decode: state and IR only. Exactly one bus source per state.
    always_comb begin
        Rin    = '0;
        Rout   = '0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        Extern = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        Busy   = (state != S_IDLE);
        case (state)
            S_T1: begin
                if (op == OP_MV) begin
                    Rout = y_hot;
                    Rin  = x_hot;
                    Done = 1'b1;
                end else if (op == OP_MVI) begin
                    Extern = 1'b1;
                    Rin    = x_hot;
                    Done   = 1'b1;
                end else begin
                    Rout = x_hot;
                    Ain  = 1'b1;
                end
            end
            S_T2: begin
                Rout   = y_hot;
                Gin    = 1'b1;
                AddSub = op[0];
            end
            S_T3: begin
                Gout = 1'b1;
                Rin  = x_hot;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// tb/tb_proc_control_unit.sv - directed and random checks of proc_control_unit
module tb_proc_control_unit;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic [5:0] Instr = 6'b0;
    logic [3:0] Rin, Rout;
    logic       Ain, Gin, Gout, Extern, AddSub, Done, Busy;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] ext_data = 4'h0;
    logic [3:0] r_q [4];
    logic [3:0] a_q = 4'h0;
    logic [3:0] g_q = 4'h0;

    logic [3:0] c_rin, c_rout;
    logic       c_ain, c_gin, c_gout, c_ext, c_addsub;

    always #5 clk = ~clk;

    proc_control_unit #(.NREG(4), .IW(6)) dut (
        .Clock  (clk),
        .Reset  (Reset),
        .Run    (Run),
        .Instr  (Instr),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .Extern (Extern),
        .AddSub (AddSub),
        .Done   (Done),
        .Busy   (Busy)
    );

    wire [14:0] outs = {Rin, Rout, Ain, Gin, Gout, Extern, AddSub, Done, Busy};

    function automatic logic [14:0] exp_outs(input logic [3:0] rin, input logic [3:0] rout,
                                             input logic ain, input logic gin, input logic gout,
                                             input logic ext, input logic addsub,
                                             input logic done, input logic busy);
        return {rin, rout, ain, gin, gout, ext, addsub, done, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controls are captured mid-cycle and applied at the next rising edge,
    // so the datapath model sees what the real datapath sees at that edge.
    initial begin
        for (int i = 0; i < 4; i++) r_q[i] = 4'h0;
    end

    always @(negedge clk) begin
        c_rin = Rin; c_rout = Rout; c_ain = Ain; c_gin = Gin;
        c_gout = Gout; c_ext = Extern; c_addsub = AddSub;
    end

    always @(posedge clk) begin
        logic [3:0] bus;
        if (!Reset) begin
            bus = 4'h0;
            if (c_ext && !c_gout)      bus = ext_data;
            else if (c_gout && !c_ext) bus = g_q;
            for (int i = 0; i < 4; i++) if (c_rout[i]) bus = r_q[i];
            if (c_gin) g_q = c_addsub ? a_q - bus : a_q + bus;
            if (c_ain) a_q = bus;
            for (int i = 0; i < 4; i++) if (c_rin[i]) r_q[i] = bus;
        end
    end

    // Present Run/Instr for one edge; returns just after the accepting edge (state T1).
    task automatic start(input logic [5:0] ins);
        @(posedge clk); #1;
        Instr = ins;
        Run   = 1'b1;
        @(posedge clk); #1;
        Run   = 1'b0;
    endtask

    task automatic do_mvi(input logic [1:0] x, input logic [3:0] d);
        logic [3:0] hot;
        hot = 4'b0001 << x;
        ext_data = d;
        start({2'b01, x, 2'b00});
        @(negedge clk);
        check("mvi_t1", outs, exp_outs(hot, 4'b0000, 0, 0, 0, 1, 0, 1, 1));
        @(negedge clk);
        check("mvi_idle", outs, 15'd0);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        check("rst_outs", outs, 15'd0);
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk);
        check("rst_release_idle", outs, 15'd0);

        // mvi R2 with spec encoding 01_10_00, then preload R1=9, R3=9, R0=5
        do_mvi(2'd2, 4'h7);
        check("r2_after_mvi", r_q[2], 4'h7);
        do_mvi(2'd1, 4'h9);
        do_mvi(2'd3, 4'h9);
        do_mvi(2'd0, 4'h5);

        // add R1,R3 : 9+9 wraps to 2; Instr changed during T1 must be ignored
        start(6'b10_01_11);
        Instr = 6'b11_11_11;
        @(negedge clk);
        check("add_t1", outs, exp_outs(4'b0000, 4'b0010, 1, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        check("add_t2", outs, exp_outs(4'b0000, 4'b1000, 0, 1, 0, 0, 0, 0, 1));
        @(negedge clk);
        check("add_t3", outs, exp_outs(4'b0010, 4'b0000, 0, 0, 1, 0, 0, 1, 1));
        @(negedge clk);
        check("add_idle", outs, 15'd0);
        check("add_r1_wrap", r_q[1], 4'h2);

        // sub R0,R0 : clears R0; Done only in the third cycle after acceptance
        start(6'b11_00_00);
        @(negedge clk);
        check("sub_t1", outs, exp_outs(4'b0000, 4'b0001, 1, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        check("sub_t2", outs, exp_outs(4'b0000, 4'b0001, 0, 1, 0, 0, 1, 0, 1));
        @(negedge clk);
        check("sub_t3", outs, exp_outs(4'b0001, 4'b0000, 0, 0, 1, 0, 0, 1, 1));
        @(negedge clk);
        check("sub_idle", outs, 15'd0);
        check("sub_r0_zero", r_q[0], 4'h0);

        // Run held high: mv R0,R1 then mv R2,R3, alternating T1/IDLE
        @(posedge clk); #1;
        Instr = 6'b00_00_01;
        Run   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_t1_a", outs, exp_outs(4'b0001, 4'b0010, 0, 0, 0, 0, 0, 1, 1));
        #1 Instr = 6'b00_10_11;
        @(negedge clk);
        check("hold_idle_a", outs, 15'd0);
        @(negedge clk);
        check("hold_t1_b", outs, exp_outs(4'b0100, 4'b1000, 0, 0, 0, 0, 0, 1, 1));
        #1 Run = 1'b0;
        @(negedge clk);
        check("hold_idle_b", outs, 15'd0);
        check("hold_r0", r_q[0], 4'h2);
        check("hold_r2", r_q[2], 4'h9);

        // Reset asserted mid-T2 of add R2,R2 drops outputs without a clock edge
        start(6'b10_10_10);
        @(negedge clk);
        check("rst_add_t1", outs, exp_outs(4'b0000, 4'b0100, 1, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        check("rst_add_t2", outs, exp_outs(4'b0000, 4'b0100, 0, 1, 0, 0, 0, 0, 1));
        #1 Reset = 1'b1;
        #1 check("rst_async", outs, 15'd0);
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk);
        check("rst_after_busy", Busy, 1'b0);
        @(negedge clk);
        check("rst_after_outs", outs, 15'd0);
        check("rst_r2_kept", r_q[2], 4'h9);

        // random Run/Instr: at most one bus source in any cycle
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            Run      = 1'($urandom_range(0, 1));
            Instr    = 6'($urandom);
            ext_data = 4'($urandom);
            @(negedge clk);
            check("bus_sources", 32'($countones(Rout)) + 32'(Gout) + 32'(Extern) <= 32'd1, 1);
        end
        Run = 1'b0;
        repeat (5) @(negedge clk);
        check("final_idle", outs, 15'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
